uart_tx_serializer: RTL and testbench

//  Transmit half of the CPLD UART datapath: parallel-in, serial-out shift register plus control FSM.

---
 rtl/uart_tx_serializer.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
// ============================================================================
// uart_tx_serializer
// ----------------------------------------------------------------------------
// Transmit half of the CPLD UART datapath. A WIDTH-bit word is captured on an
// accepted load strobe and sent on the TX line as:
//    start (0) / data LSB-first / [parity] / stop (1)
// Each bit is held for CLKS_PER_BIT clock cycles. The LSB-first order matches
// the receiver's right-shift capture, so a word sent here comes out of the
// receiver unchanged.
//
// Optional feature macro: UART_TX_PARITY_EN
//    defined   : a parity bit (even, or odd when PARITY_ODD=1) follows the data
//    undefined : no parity state or register; DATA goes straight to STOP
//
// Parameters
//    WIDTH         data bits per frame (>=1)
//    CLKS_PER_BIT  clock cycles per serial bit (>=2)
//    PARITY_ODD    0 = even parity, 1 = odd parity (parity build only)
//
// Ports
//    i_clock         system clock, all state on the rising edge
//    i_async_resetL  asynchronous, active-low reset
//    i_load_enL      active-low load strobe, honoured only while idle
//    i_parallel_in   word to transmit, sampled only when a load is accepted
//    o_serial_out    TX line, idle high (registered)
//    o_busy          high while a frame is in flight (registered)
//    o_done          one-cycle pulse on the edge that ends the stop bit
// ============================================================================
module uart_tx_serializer #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_ODD   = 0
) (
   input  logic             i_clock,
   input  logic             i_async_resetL,
   input  logic             i_load_enL,
   input  logic [WIDTH-1:0] i_parallel_in,
   output logic             o_serial_out,
   output logic             o_busy,
   output logic             o_done
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam logic PARITY_INV = (PARITY_ODD != 0);
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // PARITY_ODD only matters in the parity build; it is tied off here so the
   // parameter list stays identical between builds.
   logic unused_parity_odd;
   assign unused_parity_odd = (PARITY_ODD != 0);
`endif

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [BAUD_W-1:0] baud_q,  baud_d;
   logic [BIT_W-1:0]  bit_q,   bit_d;
   logic              serial_q, serial_d;
   logic              busy_q,   busy_d;
   logic              done_q,   done_d;
   logic              bit_end;

`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   // State register and every output flop. Reset is asynchronous so a frame
   // in flight is abandoned immediately and the TX line returns high without
   // waiting for a clock edge.
   always_ff @(posedge i_clock or negedge i_async_resetL) begin
      if (!i_async_resetL) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         baud_q   <= '0;
         bit_q    <= '0;
         serial_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         serial_q <= serial_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state logic. The baud counter runs 0..CLKS_PER_BIT-1 inside every
   // bit; reaching the last count marks a bit boundary, where the counter
   // wraps and the FSM or the data shifter advances.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      bit_end  = (baud_q == BAUD_LAST);

      case (state_q)
         S_IDLE: begin
            if (!i_load_enL) begin
               state_d  = S_START;
               shreg_d  = i_parallel_in;
               baud_d   = '0;
               bit_d    = '0;
`ifdef UART_TX_PARITY_EN
               parity_d = (^i_parallel_in) ^ PARITY_INV;
`endif
            end
         end

         S_START: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end

         S_DATA: begin
            if (bit_end) begin
               baud_d  = '0;
               shreg_d = shreg_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_STOP;
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end
`endif

         S_STOP: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode works from the *next* state and next shift register so
   // that the registered line changes on the same edge the FSM moves. This
   // keeps every output a flop while the start bit still appears on the
   // accepting edge.
   always_comb begin
      busy_d   = (state_d != S_IDLE);
      serial_d = 1'b1;
      case (state_d)
         S_START:  serial_d = 1'b0;
         S_DATA:   serial_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: serial_d = parity_d;
`endif
         default:  serial_d = 1'b1;
      endcase
   end

   assign o_serial_out = serial_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
// ============================================================================
// tb_uart_tx_serializer
// ----------------------------------------------------------------------------
// Self-checking bench for uart_tx_serializer with WIDTH=8, CLKS_PER_BIT=4,
// even parity when UART_TX_PARITY_EN is defined. Expected frames are written
// out by hand as bit vectors, bit 0 being the first bit on the line.
// ============================================================================
module tb_uart_tx_serializer;

   localparam int W = 8;
   localparam int C = 4;

`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
   localparam logic [10:0] V_A5 = 11'b1_0_1010_0101_0;
   localparam logic [10:0] V_01 = 11'b1_1_0000_0001_0;
   localparam logic [10:0] V_FF = 11'b1_0_1111_1111_0;
   localparam logic [10:0] V_00 = 11'b1_0_0000_0000_0;
   localparam logic [10:0] V_3C = 11'b1_0_0011_1100_0;
   localparam logic [10:0] V_81 = 11'b1_0_1000_0001_0;
   localparam logic [10:0] V_5A = 11'b1_0_0101_1010_0;
   localparam logic [10:0] V_07 = 11'b1_1_0000_0111_0;
`else
   localparam int FB = 10;
   localparam logic [10:0] V_A5 = 11'b0_1_1010_0101_0;
   localparam logic [10:0] V_01 = 11'b0_1_0000_0001_0;
   localparam logic [10:0] V_FF = 11'b0_1_1111_1111_0;
   localparam logic [10:0] V_00 = 11'b0_1_0000_0000_0;
   localparam logic [10:0] V_3C = 11'b0_1_0011_1100_0;
   localparam logic [10:0] V_81 = 11'b0_1_1000_0001_0;
   localparam logic [10:0] V_5A = 11'b0_1_0101_1010_0;
   localparam logic [10:0] V_07 = 11'b0_1_0000_0111_0;
`endif

   typedef struct {
      logic [7:0]  data;
      logic [10:0] bits;
   } vec_t;

   logic         i_clock;
   logic         i_async_resetL;
   logic         i_load_enL;
   logic [W-1:0] i_parallel_in;
   logic         o_serial_out;
   logic         o_busy;
   logic         o_done;

   int testsRun;
   int testsFailed;

   uart_tx_serializer #(
      .WIDTH        (W),
      .CLKS_PER_BIT (C),
      .PARITY_ODD   (0)
   ) dut (
      .i_clock        (i_clock),
      .i_async_resetL (i_async_resetL),
      .i_load_enL     (i_load_enL),
      .i_parallel_in  (i_parallel_in),
      .o_serial_out   (o_serial_out),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   // Free-running 10 ns clock, rising edges at 5, 15, 25 ...
   initial begin
      i_clock = 1'b0;
      forever #5 i_clock = ~i_clock;
   end

   // Compares the three outputs against one expected triple and logs a
   // mismatch with the step name and cycle within the frame.
   task automatic checkOutput(input string name, input int cyc,
                              input logic expSerial, input logic expBusy,
                              input logic expDone);
      testsRun++;
      if ({o_serial_out, o_busy, o_done} !== {expSerial, expBusy, expDone}) begin
         testsFailed++;
         $display("[TB] FAIL %s cycle %0d: serial/busy/done got %b%b%b, expected %b%b%b",
                  name, cyc, o_serial_out, o_busy, o_done,
                  expSerial, expBusy, expDone);
      end
   endtask

   task automatic applyStimulus(input logic loadL, input logic [W-1:0] d);
      i_load_enL    = loadL;
      i_parallel_in = d;
   endtask

   // Advance to just after the next rising edge, where outputs are sampled.
   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   // Called just after the accepting edge. Checks every cycle of the frame
   // and then the done edge. An optional event at cycle evCycle drives a new
   // word with load low; with evPulse the load is released one cycle later.
   task automatic checkFrame(input string name, input logic [10:0] bits,
                             input int evCycle, input logic [W-1:0] evData,
                             input bit evPulse);
      for (int i = 0; i < FB * C; i++) begin
         checkOutput(name, i, bits[i / C], 1'b1, 1'b0);
         if (i == evCycle) applyStimulus(1'b0, evData);
         if (evPulse && (i == evCycle + 1)) applyStimulus(1'b1, evData);
         tick();
      end
      checkOutput({name, "_done"}, FB * C, 1'b1, 1'b0, 1'b1);
   endtask

   // Single load pulse, then the whole frame plus one idle cycle. The data
   // input is scrambled right after acceptance to show it is not re-sampled.
   task automatic sendFrame(input string name, input logic [W-1:0] d,
                            input logic [10:0] bits);
      applyStimulus(1'b0, d);
      tick();
      applyStimulus(1'b1, ~d);
      checkFrame(name, bits, -1, '0, 1'b0);
      tick();
      checkOutput({name, "_idle"}, FB * C + 1, 1'b1, 1'b0, 1'b0);
   endtask

   vec_t vecs[6];

   initial begin
      testsRun    = 0;
      testsFailed = 0;

      vecs[0] = '{data: 8'hA5, bits: V_A5};
      vecs[1] = '{data: 8'h01, bits: V_01};
      vecs[2] = '{data: 8'hFF, bits: V_FF};
      vecs[3] = '{data: 8'h00, bits: V_00};
      vecs[4] = '{data: 8'h3C, bits: V_3C};
      vecs[5] = '{data: 8'h07, bits: V_07};

      // Power-on reset held over a couple of edges.
      i_async_resetL = 1'b0;
      applyStimulus(1'b1, 8'h00);
      tick();
      tick();
      checkOutput("reset", 0, 1'b1, 1'b0, 1'b0);
      i_async_resetL = 1'b1;
      tick();
      checkOutput("postReset", 0, 1'b1, 1'b0, 1'b0);

      // Table-driven single frames.
      for (int v = 0; v < 6; v++) begin
         sendFrame($sformatf("vec%0d_%02h", v, vecs[v].data), vecs[v].data, vecs[v].bits);
      end

      // Load held low: 0x3C is captured, data changes to 0xFF mid-frame and
      // is picked up on the idle edge right after o_done.
      applyStimulus(1'b0, 8'h3C);
      tick();
      checkFrame("holdLoad1", V_3C, 20, 8'hFF, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h00);
      checkFrame("holdLoad2", V_FF, -1, '0, 1'b0);
      tick();
      checkOutput("holdLoad_idle", 0, 1'b1, 1'b0, 1'b0);

      // Load pulse of 0x00 while busy must be ignored and not queued.
      applyStimulus(1'b0, 8'h5A);
      tick();
      applyStimulus(1'b1, 8'h5A);
      checkFrame("busyLoad", V_5A, 10, 8'h00, 1'b1);
      for (int i = 0; i < 2 * C; i++) begin
         tick();
         checkOutput("busyLoad_idle", i, 1'b1, 1'b0, 1'b0);
      end

      // Reset asserted between edges at cycle 17 of a frame.
      applyStimulus(1'b0, 8'h5A);
      tick();
      applyStimulus(1'b1, 8'h5A);
      for (int i = 0; i < 17; i++) begin
         checkOutput("preReset", i, V_5A[i / C], 1'b1, 1'b0);
         tick();
      end
      checkOutput("preReset", 17, V_5A[17 / C], 1'b1, 1'b0);
      #3;
      i_async_resetL = 1'b0;
      #1;
      checkOutput("midReset", 17, 1'b1, 1'b0, 1'b0);
      #2;
      i_async_resetL = 1'b1;
      tick();
      checkOutput("midReset_idle", 0, 1'b1, 1'b0, 1'b0);
      sendFrame("afterReset_81", 8'h81, V_81);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
